// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory-stage controller and MEM/WB pipeline register. A load or store held
//   in the M stage runs as one transaction on a req/ack data-memory bus. While
//   it is outstanding, upstream registers are stalled and the W stage gets
//   bubbles. When it finishes, the result is registered into the W stage.
//
//   Bus handshake: dreq rises at the edge after an access is seen in IDLE.
//   While dreq is high, dwe/daddr/dwdata are stable. The memory completes the
//   transaction with a single-cycle dack pulse, and drdata is sampled in that
//   cycle. dreq drops at the same edge. dack is ignored whenever no request is
//   outstanding. After every completion there is at least one cycle with
//   dreq=0 before the next request.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a BUSY watchdog aborts an access after TIMEOUT cycles without
//   dack. The aborted access writes back with RegWriteW=0 and MemErrW=1.
//   When undefined, BUSY waits forever and MemErrW is tied 0.
//
// Ports
//   clk, reset                    core clock, synchronous active-high reset
//   ALUResultM, WriteDataM, WA3M  M-stage data: address/ALU result, store data, dest
//   PCSrcM, RegWriteM,
//   MemWriteM, MemtoRegM          M-stage control bits
//   dreq, dwe, daddr, dwdata      data-memory request side (registered)
//   drdata, dack                  data-memory response side
//   StallM                        combinational upstream hold
//   ALUOutW, ReadDataW, WA3W,
//   PCSrcW, RegWriteW, MemtoRegW  W-stage register outputs
//   MemErrW                       timeout flag for the current W instruction
//   fsm_state_o                   debug view of the FSM state (0 IDLE, 1 BUSY)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [3:0]       WA3M,
    input  logic             PCSrcM,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    output logic             dreq,
    output logic             dwe,
    output logic [WIDTH-1:0] daddr,
    output logic [WIDTH-1:0] dwdata,
    input  logic [WIDTH-1:0] drdata,
    input  logic             dack,
    output logic             StallM,
    output logic [WIDTH-1:0] ALUOutW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [3:0]       WA3W,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             MemErrW,
    output logic             fsm_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             dreq_q, dreq_d;
    logic             dwe_q, dwe_d;
    logic [WIDTH-1:0] daddr_q, daddr_d;
    logic [WIDTH-1:0] dwdata_q, dwdata_d;
    logic [WIDTH-1:0] aluout_q, aluout_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]       wa3_q, wa3_d;
    logic             pcsrc_q, pcsrc_d;
    logic             regwrite_q, regwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic             err_q, err_d;
    logic             stall;
    logic             access;
    logic             timeout_hit;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT) < 4) ? 4 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // The counter sits at zero in IDLE, so it is cleared on every IDLE->BUSY
    // entry. It counts BUSY cycles that have no dack.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!dack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // dack in the same cycle takes priority over the abort.
    assign timeout_hit = (state_q == BUSY) && !dack && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    assign access = MemWriteM | MemtoRegM;

    always_comb begin
        state_d    = state_q;
        dreq_d     = dreq_q;
        dwe_d      = dwe_q;
        daddr_d    = daddr_q;
        dwdata_d   = dwdata_q;
        aluout_d   = aluout_q;
        rdata_d    = rdata_q;
        wa3_d      = wa3_q;
        pcsrc_d    = pcsrc_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        err_d      = 1'b0;
        stall      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!access) begin
                    aluout_d   = ALUResultM;
                    wa3_d      = WA3M;
                    pcsrc_d    = PCSrcM;
                    regwrite_d = RegWriteM;
                    memtoreg_d = MemtoRegM;
                end else begin
                    stall      = 1'b1;
                    daddr_d    = {ALUResultM[WIDTH-1:2], 2'b00};
                    dwdata_d   = WriteDataM;
                    dwe_d      = MemWriteM;
                    dreq_d     = 1'b1;
                    state_d    = BUSY;
                    // Bubble: control bits cleared, data fields hold.
                    pcsrc_d    = 1'b0;
                    regwrite_d = 1'b0;
                    memtoreg_d = 1'b0;
                end
            end
            BUSY: begin
                if (dack) begin
                    aluout_d   = ALUResultM;
                    wa3_d      = WA3M;
                    pcsrc_d    = PCSrcM;
                    regwrite_d = RegWriteM;
                    memtoreg_d = MemtoRegM;
                    if (!dwe_q) begin
                        rdata_d = drdata;
                    end
                    dreq_d  = 1'b0;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    // Aborted access retires without any register write.
                    aluout_d   = ALUResultM;
                    wa3_d      = WA3M;
                    pcsrc_d    = PCSrcM;
                    regwrite_d = 1'b0;
                    memtoreg_d = 1'b0;
                    rdata_d    = '0;
                    err_d      = 1'b1;
                    dreq_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    stall      = 1'b1;
                    pcsrc_d    = 1'b0;
                    regwrite_d = 1'b0;
                    memtoreg_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dreq_q     <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
            aluout_q   <= '0;
            rdata_q    <= '0;
            wa3_q      <= '0;
            pcsrc_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dreq_q     <= dreq_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            dwdata_q   <= dwdata_d;
            aluout_q   <= aluout_d;
            rdata_q    <= rdata_d;
            wa3_q      <= wa3_d;
            pcsrc_q    <= pcsrc_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            err_q      <= err_d;
        end
    end

    // Reset overrides the stall so upstream is never frozen during reset.
    assign StallM      = stall & ~reset;
    assign dreq        = dreq_q;
    assign dwe         = dwe_q;
    assign daddr       = daddr_q;
    assign dwdata      = dwdata_q;
    assign ALUOutW     = aluout_q;
    assign ReadDataW   = rdata_q;
    assign WA3W        = wa3_q;
    assign PCSrcW      = pcsrc_q;
    assign RegWriteW   = regwrite_q;
    assign MemtoRegW   = memtoreg_q;
    assign MemErrW     = err_q;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ALUResultM = '0, WriteDataM = '0, drdata = '0;
  logic [3:0]  WA3M = '0;
  logic        PCSrcM = 0, RegWriteM = 0, MemWriteM = 0, MemtoRegM = 0, dack = 0;
  logic        dreq, dwe, StallM, PCSrcW, RegWriteW, MemtoRegW, MemErrW, fsm_state_o;
  logic [31:0] daddr, dwdata, ALUOutW, ReadDataW;
  logic [3:0]  WA3W;

  int passed = 0;
  int total  = 0;

  // Reference W-stage contents, maintained from the instruction-level rules.
  logic [31:0] exp_alu, exp_rd;
  logic [3:0]  exp_wa3;

  mem_wb_stage #(.WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dack(dack), .StallM(StallM),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WA3W(WA3W),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .MemErrW(MemErrW), .fsm_state_o(fsm_state_o)
  );

  // clock
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_m(input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa3,
                         input logic pcs, input logic rw, input logic mw, input logic m2r);
    ALUResultM = alu; WriteDataM = wd; WA3M = wa3;
    PCSrcM = pcs; RegWriteM = rw; MemWriteM = mw; MemtoRegM = m2r;
  endtask

  task automatic idle_inputs();
    drive_m(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    dack = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b1;
      drive_m($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      dack = 1'($urandom_range(0, 1));
      drdata = $urandom;
      #1;
      total++; if (StallM !== 1'b0) $display("FAIL reset_stall: got %b want 0", StallM); else passed++;
    end
    @(posedge clk); #1;
    total++;
    if ({dreq, dwe, daddr, dwdata, ALUOutW, ReadDataW, WA3W, PCSrcW, RegWriteW, MemtoRegW, MemErrW, fsm_state_o} !== '0)
      $display("FAIL reset_outputs: dreq=%b dwe=%b daddr=%h dwdata=%h alu=%h rd=%h wa3=%h ctl=%b%b%b err=%b st=%b want all 0",
               dreq, dwe, daddr, dwdata, ALUOutW, ReadDataW, WA3W, PCSrcW, RegWriteW, MemtoRegW, MemErrW, fsm_state_o);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    #1;
    total++; if (StallM !== 1'b0 || dreq !== 1'b0) $display("FAIL reset_release: stall=%b dreq=%b want 0 0", StallM, dreq); else passed++;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_m(32'h0000_00A5, 32'h0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (StallM !== 1'b0) $display("FAIL alu_stall: got %b want 0", StallM); else passed++;
    @(posedge clk); #1;
    total++; if (ALUOutW !== 32'hA5) $display("FAIL alu_out: got %h want 000000a5", ALUOutW); else passed++;
    total++;
    if (WA3W !== 4'd3 || RegWriteW !== 1'b1 || MemtoRegW !== 1'b0 || PCSrcW !== 1'b0)
      $display("FAIL alu_ctl: wa3=%0d rw=%b m2r=%b pcs=%b want 3 1 0 0", WA3W, RegWriteW, MemtoRegW, PCSrcW);
    else passed++;
  endtask

  // Load at 0x1007 with dack in the third request cycle.
  task automatic test_load();
    int stalls = 0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      drive_m(32'h0000_1007, 32'h0, 4'd5, 1'b0, 1'b1, 1'b0, 1'b1);
      dack = (c == 3);
      drdata = (c == 3) ? 32'hDEAD_BEEF : $urandom;
      #1;
      if (StallM === 1'b1) stalls++;
      total++; if (dreq !== (c >= 1)) $display("FAIL load_dreq_c%0d: got %b want %b", c, dreq, (c >= 1)); else passed++;
      @(posedge clk); #1;
      if (c == 0) begin
        total++; if (daddr !== 32'h1004 || dwe !== 1'b0) $display("FAIL load_addr: daddr=%h dwe=%b want 00001004 0", daddr, dwe); else passed++;
      end
      if (c < 3) begin
        total++;
        if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0 || ALUOutW !== 32'hA5 || WA3W !== 4'd3)
          $display("FAIL load_bubble_c%0d: rw=%b m2r=%b alu=%h wa3=%0d want 0 0 000000a5 3", c, RegWriteW, MemtoRegW, ALUOutW, WA3W);
        else passed++;
      end
    end
    total++; if (stalls != 3) $display("FAIL load_stall_cycles: got %0d want 3", stalls); else passed++;
    total++;
    if (ReadDataW !== 32'hDEAD_BEEF || MemtoRegW !== 1'b1 || RegWriteW !== 1'b1 || ALUOutW !== 32'h1007 || WA3W !== 4'd5 || dreq !== 1'b0)
      $display("FAIL load_done: rd=%h m2r=%b rw=%b alu=%h wa3=%0d dreq=%b want deadbeef 1 1 00001007 5 0",
               ReadDataW, MemtoRegW, RegWriteW, ALUOutW, WA3W, dreq);
    else passed++;
  endtask

  // Store (dack after one cycle), then a load issued immediately, then dack in IDLE.
  task automatic test_store_then_load();
    logic [31:0] rd1, rd2;
    rd1 = $urandom;
    rd2 = ~rd1;
    @(negedge clk);
    drive_m(32'h20, 32'h1234_5678, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0);
    dack = 1'b0;
    #1;
    total++; if (StallM !== 1'b1) $display("FAIL store_stall: got %b want 1", StallM); else passed++;
    @(posedge clk); #1;
    total++;
    if (dreq !== 1'b1 || dwe !== 1'b1 || dwdata !== 32'h1234_5678 || daddr !== 32'h20)
      $display("FAIL store_req: dreq=%b dwe=%b dwdata=%h daddr=%h want 1 1 12345678 00000020", dreq, dwe, dwdata, daddr);
    else passed++;
    @(negedge clk);
    dack = 1'b1;
    drdata = $urandom;
    #1;
    total++; if (StallM !== 1'b0) $display("FAIL store_ack_stall: got %b want 0", StallM); else passed++;
    @(posedge clk); #1;
    total++;
    if (ReadDataW !== 32'hDEAD_BEEF || ALUOutW !== 32'h20 || WA3W !== 4'd7 || RegWriteW !== 1'b0 || dreq !== 1'b0)
      $display("FAIL store_done: rd=%h alu=%h wa3=%0d rw=%b dreq=%b want deadbeef 00000020 7 0 0", ReadDataW, ALUOutW, WA3W, RegWriteW, dreq);
    else passed++;
    // next access follows at once: the gap cycle must show dreq low
    @(negedge clk);
    drive_m(32'h44, 32'h0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    dack = 1'b0;
    #1;
    total++; if (dreq !== 1'b0 || StallM !== 1'b1) $display("FAIL b2b_gap: dreq=%b stall=%b want 0 1", dreq, StallM); else passed++;
    @(posedge clk); #1;
    total++; if (dreq !== 1'b1 || daddr !== 32'h44) $display("FAIL b2b_req: dreq=%b daddr=%h want 1 00000044", dreq, daddr); else passed++;
    @(negedge clk);
    dack = 1'b1;
    drdata = rd1;
    @(posedge clk); #1;
    total++; if (ReadDataW !== rd1 || MemtoRegW !== 1'b1) $display("FAIL b2b_load: rd=%h m2r=%b want %h 1", ReadDataW, MemtoRegW, rd1); else passed++;
    // stray dack with no request outstanding
    @(negedge clk);
    idle_inputs();
    dack = 1'b1;
    drdata = rd2;
    @(posedge clk); #1;
    total++;
    if (ReadDataW !== rd1 || dreq !== 1'b0 || fsm_state_o !== 1'b0)
      $display("FAIL idle_dack: rd=%h dreq=%b st=%b want %h 0 0", ReadDataW, dreq, fsm_state_o, rd1);
    else passed++;
  endtask

  task automatic test_reset_busy();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive_m(32'h80, 32'h0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
      dack = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (StallM !== 1'b0) $display("FAIL rst_busy_stall: got %b want 0", StallM); else passed++;
    @(posedge clk); #1;
    total++;
    if ({dreq, ALUOutW, ReadDataW, WA3W, PCSrcW, RegWriteW, MemtoRegW, MemErrW} !== '0)
      $display("FAIL rst_busy_out: dreq=%b alu=%h rd=%h wa3=%0d ctl=%b%b%b err=%b want all 0",
               dreq, ALUOutW, ReadDataW, WA3W, PCSrcW, RegWriteW, MemtoRegW, MemErrW);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    dack = 1'b1;
    drdata = $urandom | 32'h1;
    #1;
    total++; if (StallM !== 1'b0) $display("FAIL late_dack_stall: got %b want 0", StallM); else passed++;
    @(posedge clk); #1;
    total++;
    if (dreq !== 1'b0 || ReadDataW !== 32'h0 || ALUOutW !== 32'h0 || RegWriteW !== 1'b0)
      $display("FAIL late_dack: dreq=%b rd=%h alu=%h rw=%b want 0 0 0 0", dreq, ReadDataW, ALUOutW, RegWriteW);
    else passed++;
  endtask

  // Random instruction stream: ALU ops, loads and stores with random latency.
  task automatic test_random();
    logic [31:0] alu, wd, rd;
    logic [3:0]  wa3;
    logic        pcs, rw, mw, m2r;
    int          kind, k;
    exp_alu = '0; exp_rd = '0; exp_wa3 = '0;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      alu = $urandom; wd = $urandom; rd = $urandom;
      wa3 = 4'($urandom_range(0, 15));
      pcs = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      mw  = (kind == 2);
      m2r = (kind == 1);
      k   = (kind == 0) ? 0 : $urandom_range(1, 4);
      for (int c = 0; c <= k; c++) begin
        @(negedge clk);
        drive_m(alu, wd, wa3, pcs, rw, mw, m2r);
        dack   = (kind == 0) ? 1'($urandom_range(0, 1)) : (c == k);
        drdata = (c == k) ? rd : $urandom;
        #1;
        total++; if (StallM !== (c < k)) $display("FAIL rnd_stall n%0d c%0d: got %b want %b", n, c, StallM, (c < k)); else passed++;
        total++; if (dreq !== (c >= 1)) $display("FAIL rnd_dreq n%0d c%0d: got %b want %b", n, c, dreq, (c >= 1)); else passed++;
        @(posedge clk); #1;
        if (c == 0 && k > 0) begin
          total++;
          if (dwe !== mw || daddr !== {alu[31:2], 2'b00} || dwdata !== wd)
            $display("FAIL rnd_req n%0d: dwe=%b daddr=%h dwdata=%h want %b %h %h", n, dwe, daddr, dwdata, mw, {alu[31:2], 2'b00}, wd);
          else passed++;
        end
        if (c < k) begin
          total++;
          if (RegWriteW !== 1'b0 || MemtoRegW !== 1'b0 || PCSrcW !== 1'b0 || ALUOutW !== exp_alu || WA3W !== exp_wa3 || ReadDataW !== exp_rd)
            $display("FAIL rnd_bubble n%0d c%0d: ctl=%b%b%b alu=%h wa3=%0d rd=%h want 000 %h %0d %h",
                     n, c, PCSrcW, RegWriteW, MemtoRegW, ALUOutW, WA3W, ReadDataW, exp_alu, exp_wa3, exp_rd);
          else passed++;
        end else begin
          exp_alu = alu;
          exp_wa3 = wa3;
          if (kind == 1) exp_rd = rd;
          total++;
          if (ALUOutW !== exp_alu || WA3W !== exp_wa3 || ReadDataW !== exp_rd || PCSrcW !== pcs ||
              RegWriteW !== rw || MemtoRegW !== m2r || MemErrW !== 1'b0)
            $display("FAIL rnd_wb n%0d: alu=%h wa3=%0d rd=%h ctl=%b%b%b err=%b want %h %0d %h %b%b%b 0",
                     n, ALUOutW, WA3W, ReadDataW, PCSrcW, RegWriteW, MemtoRegW, MemErrW,
                     exp_alu, exp_wa3, exp_rd, pcs, rw, m2r);
          else passed++;
        end
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  // Load with no dack aborts on the 15th BUSY cycle; with dack on that cycle it completes.
  task automatic test_timeout();
    logic [31:0] alu, rd;
    logic        ack_last;
    for (int rep = 0; rep < 2; rep++) begin
      ack_last = (rep == 1);
      alu = $urandom;
      rd  = $urandom | 32'h1;
      for (int c = 0; c <= 15; c++) begin
        @(negedge clk);
        drive_m(alu, 32'h0, 4'd11, 1'b0, 1'b1, 1'b0, 1'b1);
        dack   = ack_last && (c == 15);
        drdata = rd;
        #1;
        total++; if (StallM !== (c < 15)) $display("FAIL to_stall r%0d c%0d: got %b want %b", rep, c, StallM, (c < 15)); else passed++;
        @(posedge clk); #1;
        if (c == 14) begin
          total++; if (dreq !== 1'b1 || MemErrW !== 1'b0) $display("FAIL to_pre r%0d: dreq=%b err=%b want 1 0", rep, dreq, MemErrW); else passed++;
        end
      end
      if (!ack_last) begin
        total++;
        if (MemErrW !== 1'b1 || RegWriteW !== 1'b0 || MemtoRegW !== 1'b0 || ReadDataW !== 32'h0 || ALUOutW !== alu || WA3W !== 4'd11 || dreq !== 1'b0)
          $display("FAIL to_abort: err=%b rw=%b m2r=%b rd=%h alu=%h wa3=%0d dreq=%b want 1 0 0 0 %h 11 0",
                   MemErrW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W, dreq, alu);
        else passed++;
      end else begin
        total++;
        if (MemErrW !== 1'b0 || RegWriteW !== 1'b1 || MemtoRegW !== 1'b1 || ReadDataW !== rd || dreq !== 1'b0)
          $display("FAIL to_ack_wins: err=%b rw=%b m2r=%b rd=%h dreq=%b want 0 1 1 %h 0", MemErrW, RegWriteW, MemtoRegW, ReadDataW, dreq, rd);
        else passed++;
      end
      @(negedge clk);
      idle_inputs();
      @(posedge clk); #1;
      total++; if (MemErrW !== 1'b0) $display("FAIL to_err_pulse r%0d: got %b want 0", rep, MemErrW); else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_then_load();
    test_reset_busy();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
